// File: rtl/rpc_delay_calib_if.sv
// Handshake and result bundle between the delay calibrator and its environment.
// The slave modport is the calibrator's view; master is the requester/training-read side.
interface rpc_delay_calib_if #(
    parameter int DelayWidth = 5
);
    logic                  start_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  fail_o;
    logic [DelayWidth-1:0] delay_o;
    logic                  probe_req_o;
    logic                  probe_ack_i;
    logic                  probe_pass_i;
    logic [DelayWidth-1:0] win_lo_o;
    logic [DelayWidth-1:0] win_hi_o;

    modport slave (
        input  start_i, probe_ack_i, probe_pass_i,
        output busy_o, done_o, fail_o, delay_o, probe_req_o, win_lo_o, win_hi_o
    );

    modport master (
        output start_i, probe_ack_i, probe_pass_i,
        input  busy_o, done_o, fail_o, delay_o, probe_req_o, win_lo_o, win_hi_o
    );
endinterface

// File: rtl/rpc_delay_calib.sv
// Read-delay calibrator: sweeps every tap of a programmable delay line, finds the
// longest passing window (lowest wins on ties) and parks the delay at its centre.
module rpc_delay_calib #(
    parameter int DelayWidth   = 5,
    parameter int SettleCycles = 4,
    parameter int MinWindow    = 3,
    parameter int DefaultDelay = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    rpc_delay_calib_if.slave     bus
);
    localparam int LenWidth = DelayWidth + 1;
    localparam int CntWidth = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [DelayWidth-1:0] LastTap = {DelayWidth{1'b1}};

    typedef enum logic [2:0] {IDLE, SETTLE, PROBE, EVAL, DONE} state_e;

    state_e                state_q, state_d;
    logic [DelayWidth-1:0] d_q, d_d;
    logic [DelayWidth-1:0] delay_q, delay_d;
    logic [DelayWidth-1:0] saved_delay_q, saved_delay_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DelayWidth-1:0] run_lo_q, run_lo_d;
    logic [LenWidth-1:0]   run_len_q, run_len_d;
    logic [DelayWidth-1:0] best_lo_q, best_lo_d;
    logic [LenWidth-1:0]   best_len_q, best_len_d;
    logic [DelayWidth-1:0] win_lo_q, win_lo_d;
    logic [DelayWidth-1:0] win_hi_q, win_hi_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  probe_req_q, probe_req_d;
    logic [DelayWidth-1:0] ext_lo_s;
    logic [LenWidth-1:0]   ext_len_s;

    // Next-state and next-output logic for the sweep controller.
    always_comb begin
        state_d       = state_q;
        d_d           = d_q;
        delay_d       = delay_q;
        saved_delay_d = saved_delay_q;
        cnt_d         = cnt_q;
        run_lo_d      = run_lo_q;
        run_len_d     = run_len_q;
        best_lo_d     = best_lo_q;
        best_len_d    = best_len_q;
        win_lo_d      = win_lo_q;
        win_hi_d      = win_hi_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        done_d        = 1'b0;
        probe_req_d   = 1'b0;
        ext_lo_s      = run_lo_q;
        ext_len_s     = run_len_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d       = SETTLE;
                    saved_delay_d = delay_q;
                    d_d           = {DelayWidth{1'b0}};
                    delay_d       = {DelayWidth{1'b0}};
                    cnt_d         = CntWidth'(SettleCycles - 1);
                    run_lo_d      = {DelayWidth{1'b0}};
                    run_len_d     = {LenWidth{1'b0}};
                    best_lo_d     = {DelayWidth{1'b0}};
                    best_len_d    = {LenWidth{1'b0}};
                    fail_d        = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == {CntWidth{1'b0}}) begin
                    state_d     = PROBE;
                    probe_req_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            PROBE: begin
                if (bus.probe_ack_i) begin
                    pass_d  = bus.probe_pass_i;
                    state_d = EVAL;
                end else begin
                    probe_req_d = 1'b1;
                end
            end
            EVAL: begin
                // ext_* is the run as it stands after this tap's result.
                if (pass_q) begin
                    ext_lo_s  = (run_len_q == {LenWidth{1'b0}}) ? d_q : run_lo_q;
                    ext_len_s = run_len_q + LenWidth'(1);
                end else begin
                    ext_lo_s  = run_lo_q;
                    ext_len_s = run_len_q;
                end
                if (!pass_q || (d_q == LastTap)) begin
                    if (ext_len_s > best_len_q) begin
                        best_lo_d  = ext_lo_s;
                        best_len_d = ext_len_s;
                    end else begin
                        best_lo_d  = best_lo_q;
                    end
                    run_len_d = {LenWidth{1'b0}};
                end else begin
                    run_lo_d  = ext_lo_s;
                    run_len_d = ext_len_s;
                end
                if (d_q == LastTap) begin
                    state_d = DONE;
                end else begin
                    d_d     = d_q + DelayWidth'(1);
                    delay_d = d_q + DelayWidth'(1);
                    cnt_d   = CntWidth'(SettleCycles - 1);
                    state_d = SETTLE;
                end
            end
            DONE: begin
                if (best_len_q >= LenWidth'(MinWindow)) begin
                    delay_d  = best_lo_q + DelayWidth'((best_len_q - LenWidth'(1)) >> 1);
                    win_lo_d = best_lo_q;
                    win_hi_d = best_lo_q + DelayWidth'(best_len_q - LenWidth'(1));
                    fail_d   = 1'b0;
                end else begin
                    delay_d = saved_delay_q;
                    fail_d  = 1'b1;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SETTLE) || (state_d == PROBE) || (state_d == EVAL);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            d_q           <= {DelayWidth{1'b0}};
            delay_q       <= DelayWidth'(DefaultDelay);
            saved_delay_q <= DelayWidth'(DefaultDelay);
            cnt_q         <= {CntWidth{1'b0}};
            run_lo_q      <= {DelayWidth{1'b0}};
            run_len_q     <= {LenWidth{1'b0}};
            best_lo_q     <= {DelayWidth{1'b0}};
            best_len_q    <= {LenWidth{1'b0}};
            win_lo_q      <= {DelayWidth{1'b0}};
            win_hi_q      <= {DelayWidth{1'b0}};
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            probe_req_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            d_q           <= d_d;
            delay_q       <= delay_d;
            saved_delay_q <= saved_delay_d;
            cnt_q         <= cnt_d;
            run_lo_q      <= run_lo_d;
            run_len_q     <= run_len_d;
            best_lo_q     <= best_lo_d;
            best_len_q    <= best_len_d;
            win_lo_q      <= win_lo_d;
            win_hi_q      <= win_hi_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            probe_req_q   <= probe_req_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.fail_o      = fail_q;
    assign bus.delay_o     = delay_q;
    assign bus.probe_req_o = probe_req_q;
    assign bus.win_lo_o    = win_lo_q;
    assign bus.win_hi_o    = win_hi_q;
endmodule

// File: tb/tb_rpc_delay_calib.sv
// Directed bench for rpc_delay_calib: table of tap pass patterns with expected
// windows, plus hand sequences for settle spacing, ignored starts and mid-probe reset.
module tb_rpc_delay_calib;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   chg_cyc;
    int   probes;
    int   ack_lat;
    int   stop_tap;
    logic [31:0] pattern;
    logic [4:0]  prev_delay;
    logic        prev_req;

    typedef struct {
        logic [31:0] pattern;
        int          lat;
        logic [4:0]  exp_lo;
        logic [4:0]  exp_hi;
        logic [4:0]  exp_delay;
        logic        exp_fail;
    } vec_t;

    vec_t vecs[5];

    rpc_delay_calib_if #(.DelayWidth(5)) bus ();

    rpc_delay_calib #(
        .DelayWidth(5), .SettleCycles(4), .MinWindow(3), .DefaultDelay(16)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Training-read responder: acks each request ack_lat cycles later with the pattern bit.
    initial begin
        bus.probe_ack_i  = 1'b0;
        bus.probe_pass_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.probe_req_o && int'(bus.delay_o) != stop_tap) begin
                probes++;
                repeat (ack_lat - 1) @(negedge clk);
                bus.probe_ack_i  = 1'b1;
                bus.probe_pass_i = pattern[bus.delay_o];
                @(negedge clk);
                bus.probe_ack_i  = 1'b0;
                bus.probe_pass_i = 1'b0;
            end
        end
    end

    // Settle spacing monitor: cycles from a delay code change to the next request rise.
    initial begin
        cyc = 0; chg_cyc = 0; prev_delay = 5'd0; prev_req = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.delay_o != prev_delay) chg_cyc = cyc;
            if (rst_n && bus.probe_req_o && !prev_req)
                check("settle_spacing", cyc - chg_cyc, 32'd4);
            prev_delay = bus.delay_o;
            prev_req   = bus.probe_req_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int dones;
        n_checks = 0; n_fail = 0; probes = 0; ack_lat = 1; stop_tap = -1; pattern = 32'h0;
        bus.start_i = 1'b0;

        vecs[0] = '{32'h001F_FC00, 2, 5'd10, 5'd20, 5'd15, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 1, 5'd0,  5'd31, 5'd15, 1'b0};
        vecs[2] = '{32'h01F0_007C, 3, 5'd2,  5'd6,  5'd4,  1'b0};
        vecs[3] = '{32'h0007_C000, 1, 5'd14, 5'd18, 5'd16, 1'b0};
        vecs[4] = '{32'h0000_0060, 2, 5'd14, 5'd18, 5'd16, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_delay", bus.delay_o, 32'd16);
        check("rst_busy", bus.busy_o, 32'd0);
        check("rst_done", bus.done_o, 32'd0);
        check("rst_fail", bus.fail_o, 32'd0);
        check("rst_req", bus.probe_req_o, 32'd0);
        check("rst_win_lo", bus.win_lo_o, 32'd0);
        check("rst_win_hi", bus.win_hi_o, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            pattern = vecs[i].pattern;
            ack_lat = vecs[i].lat;
            probes  = 0;
            bus.start_i = 1'b1;
            @(negedge clk);
            bus.start_i = 1'b0;
            check($sformatf("v%0d_busy_start", i), bus.busy_o, 32'd1);
            check($sformatf("v%0d_fail_clr", i), bus.fail_o, 32'd0);
            check($sformatf("v%0d_delay_start", i), bus.delay_o, 32'd0);
            got = 1'b0;
            for (int c = 0; c < 3000 && !got; c++) begin
                @(negedge clk);
                bus.start_i = (c == 40 || c == 150) ? 1'b1 : 1'b0;
                if (bus.done_o) got = 1'b1;
            end
            bus.start_i = 1'b0;
            check($sformatf("v%0d_done_seen", i), got, 32'd1);
            check($sformatf("v%0d_win_lo", i), bus.win_lo_o, vecs[i].exp_lo);
            check($sformatf("v%0d_win_hi", i), bus.win_hi_o, vecs[i].exp_hi);
            check($sformatf("v%0d_delay", i), bus.delay_o, vecs[i].exp_delay);
            check($sformatf("v%0d_fail", i), bus.fail_o, vecs[i].exp_fail);
            check($sformatf("v%0d_busy_done", i), bus.busy_o, 32'd0);
            check($sformatf("v%0d_probes", i), probes, 32'd32);
            @(negedge clk);
            check($sformatf("v%0d_done_1cyc", i), bus.done_o, 32'd0);
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_fail_sticky", i), bus.fail_o, vecs[i].exp_fail);
            check($sformatf("v%0d_idle_probes", i), probes, 32'd32);
        end

        // Reset while a probe at tap 12 is outstanding.
        pattern  = 32'hFFFF_FFFF;
        ack_lat  = 1;
        stop_tap = 12;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("rstp_fail_clr", bus.fail_o, 32'd0);
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            if (bus.probe_req_o && bus.delay_o == 5'd12) got = 1'b1;
        end
        check("rstp_reached_tap12", got, 32'd1);
        repeat (2) @(negedge clk);
        check("rstp_req_held", bus.probe_req_o, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstp_req", bus.probe_req_o, 32'd0);
        check("rstp_busy", bus.busy_o, 32'd0);
        check("rstp_done", bus.done_o, 32'd0);
        check("rstp_delay", bus.delay_o, 32'd16);
        check("rstp_win_lo", bus.win_lo_o, 32'd0);
        check("rstp_win_hi", bus.win_hi_o, 32'd0);
        rst_n    = 1'b1;
        stop_tap = -1;
        dones    = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        check("rstp_no_done", dones, 32'd0);
        check("rstp_idle_busy", bus.busy_o, 32'd0);
        check("rstp_idle_req", bus.probe_req_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
